// File: rtl/traffic_lamp_driver.sv
// traffic_lamp_driver
// Turns the per-cycle car/pedestrian phase codes into lamp drives.
// It also generates the pedestrian blink and the walk countdown.
// A safety monitor latches the first illegal or conflicting phase it sees
// and holds a flashing-yellow fail-safe until rst_n is asserted.
// All outputs are registered: inputs sampled at edge N show up after edge N.
//
// Input contract: i_car_light / i_hmn_light are sampled on every rising clk
// edge. There is no valid/ready handshake; every edge carries a phase code.
module traffic_lamp_driver #(
    parameter int BLINK_HALF  = 2,
    parameter int WALK_CYCLES = 20,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       i_car_light,
    input  logic [1:0]       i_hmn_light,
    output logic             o_car_r,
    output logic             o_car_y,
    output logic             o_car_g,
    output logic             o_car_arrow,
    output logic             o_hmn_r,
    output logic             o_hmn_g,
    output logic [CNT_W-1:0] o_walk_cnt,
    output logic             o_walk_vld,
    output logic             o_fault,
    output logic [1:0]       o_fault_code,
    output logic             o_dbg_state
);

    // Car phase encodings
    localparam logic [1:0] CAR_RED    = 2'b00;
    localparam logic [1:0] CAR_GREEN  = 2'b01;
    localparam logic [1:0] CAR_YELLOW = 2'b10;
    localparam logic [1:0] CAR_LEFT   = 2'b11;

    // Pedestrian phase encodings
    localparam logic [1:0] HMN_RED     = 2'b00;
    localparam logic [1:0] HMN_GREEN   = 2'b01;
    localparam logic [1:0] HMN_BLINK   = 2'b10;
    localparam logic [1:0] HMN_ILLEGAL = 2'b11;

    // Fault causes
    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_CONFLICT = 2'b01;
    localparam logic [1:0] FC_CAR      = 2'b10;
    localparam logic [1:0] FC_HMN      = 2'b11;

    // Blink/flash phase index runs 0 .. 2*BLINK_HALF-1; ON while below BLINK_HALF
    localparam int            BW         = $clog2(2 * BLINK_HALF);
    localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_HALF - 1);
    localparam logic [BW-1:0] BLINK_ON   = BW'(BLINK_HALF);

    localparam logic [CNT_W-1:0] WALK_LOAD = CNT_W'(WALK_CYCLES - 1);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FAULT  = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_prev_car;
    logic [1:0]       r_prev_hmn;
    logic [BW-1:0]    r_blink_idx;
    logic [BW-1:0]    r_flash_idx;
    logic             r_car_r;
    logic             r_car_y;
    logic             r_car_g;
    logic             r_car_arrow;
    logic             r_hmn_r;
    logic             r_hmn_g;
    logic [CNT_W-1:0] r_walk_cnt;
    logic             r_walk_vld;
    logic             r_fault;
    logic [1:0]       r_fault_code;

    logic             w_conflict;
    logic             w_car_legal;
    logic             w_hmn_legal;
    logic [1:0]       w_fault_code;
    logic [BW-1:0]    w_blink_next;
    logic [BW-1:0]    w_flash_next;
    logic [CNT_W-1:0] w_walk_cnt_next;
    logic             w_walk_vld_next;

    // A walking pedestrian while cars may move is the most dangerous case
    assign w_conflict = ((i_hmn_light == HMN_GREEN) || (i_hmn_light == HMN_BLINK))
                        && (i_car_light != CAR_RED);

    // Legal car sequence: RED -> GREEN -> YELLOW -> (LEFT <-> YELLOW) -> RED
    always_comb begin
        w_car_legal = 1'b0;
        if (i_car_light == r_prev_car) begin
            w_car_legal = 1'b1;
        end else begin
            case ({r_prev_car, i_car_light})
                {CAR_RED,    CAR_GREEN},
                {CAR_GREEN,  CAR_YELLOW},
                {CAR_YELLOW, CAR_LEFT},
                {CAR_YELLOW, CAR_RED},
                {CAR_LEFT,   CAR_YELLOW}: w_car_legal = 1'b1;
                default:                  w_car_legal = 1'b0;
            endcase
        end
    end

    // Legal pedestrian sequence: RED -> GREEN -> BLINK -> RED; code 11 never legal
    always_comb begin
        w_hmn_legal = 1'b0;
        if (i_hmn_light == HMN_ILLEGAL) begin
            w_hmn_legal = 1'b0;
        end else if (i_hmn_light == r_prev_hmn) begin
            w_hmn_legal = 1'b1;
        end else begin
            case ({r_prev_hmn, i_hmn_light})
                {HMN_RED,   HMN_GREEN},
                {HMN_GREEN, HMN_BLINK},
                {HMN_BLINK, HMN_RED}: w_hmn_legal = 1'b1;
                default:              w_hmn_legal = 1'b0;
            endcase
        end
    end

    // Priority encode the checks; the first failing check names the fault
    always_comb begin
        w_fault_code = FC_NONE;
        if (w_conflict) begin
            w_fault_code = FC_CONFLICT;
        end else if (!w_car_legal) begin
            w_fault_code = FC_CAR;
        end else if (!w_hmn_legal) begin
            w_fault_code = FC_HMN;
        end
    end

    // Blink phase restarts ON whenever BLINK is entered from another phase
    always_comb begin
        w_blink_next = '0;
        if (r_prev_hmn == HMN_BLINK) begin
            w_blink_next = (r_blink_idx == BLINK_LAST) ? '0 : r_blink_idx + 1'b1;
        end
    end

    // Fault flash keeps running from the index loaded on the entry edge
    always_comb begin
        w_flash_next = (r_flash_idx == BLINK_LAST) ? '0 : r_flash_idx + 1'b1;
    end

    // Walk countdown: load on the RED->GREEN edge, count down through GREEN/BLINK
    always_comb begin
        w_walk_cnt_next = '0;
        w_walk_vld_next = 1'b0;
        if ((i_hmn_light == HMN_GREEN) && (r_prev_hmn == HMN_RED)) begin
            w_walk_cnt_next = WALK_LOAD;
            w_walk_vld_next = 1'b1;
        end else if ((i_hmn_light == HMN_GREEN) || (i_hmn_light == HMN_BLINK)) begin
            w_walk_cnt_next = (r_walk_cnt == '0) ? '0 : r_walk_cnt - 1'b1;
            w_walk_vld_next = r_walk_vld;
        end
    end

    // NORMAL/FAULT state machine with all lamp and status outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_NORMAL;
            r_prev_car   <= CAR_RED;
            r_prev_hmn   <= HMN_RED;
            r_blink_idx  <= '0;
            r_flash_idx  <= '0;
            r_car_r      <= 1'b1;
            r_car_y      <= 1'b0;
            r_car_g      <= 1'b0;
            r_car_arrow  <= 1'b0;
            r_hmn_r      <= 1'b1;
            r_hmn_g      <= 1'b0;
            r_walk_cnt   <= '0;
            r_walk_vld   <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
        end else begin
            case (r_state)
                ST_NORMAL: begin
                    if (w_fault_code != FC_NONE) begin
                        // The entry edge already drives the fail-safe pattern
                        r_state      <= ST_FAULT;
                        r_fault      <= 1'b1;
                        r_fault_code <= w_fault_code;
                        r_flash_idx  <= '0;
                        r_car_r      <= 1'b0;
                        r_car_y      <= 1'b1;
                        r_car_g      <= 1'b0;
                        r_car_arrow  <= 1'b0;
                        r_hmn_r      <= 1'b0;
                        r_hmn_g      <= 1'b0;
                        r_walk_cnt   <= '0;
                        r_walk_vld   <= 1'b0;
                    end else begin
                        r_prev_car  <= i_car_light;
                        r_prev_hmn  <= i_hmn_light;
                        r_car_r     <= (i_car_light == CAR_RED) || (i_car_light == CAR_LEFT);
                        r_car_y     <= (i_car_light == CAR_YELLOW);
                        r_car_g     <= (i_car_light == CAR_GREEN);
                        r_car_arrow <= (i_car_light == CAR_LEFT);
                        r_hmn_r     <= (i_hmn_light == HMN_RED);
                        if (i_hmn_light == HMN_BLINK) begin
                            r_blink_idx <= w_blink_next;
                            r_hmn_g     <= (w_blink_next < BLINK_ON);
                        end else begin
                            r_blink_idx <= '0;
                            r_hmn_g     <= (i_hmn_light == HMN_GREEN);
                        end
                        r_walk_cnt <= w_walk_cnt_next;
                        r_walk_vld <= w_walk_vld_next;
                    end
                end
                ST_FAULT: begin
                    // Inputs are ignored; only the yellow flash advances
                    r_flash_idx <= w_flash_next;
                    r_car_r     <= 1'b0;
                    r_car_y     <= (w_flash_next < BLINK_ON);
                    r_car_g     <= 1'b0;
                    r_car_arrow <= 1'b0;
                    r_hmn_r     <= 1'b0;
                    r_hmn_g     <= 1'b0;
                    r_walk_cnt  <= '0;
                    r_walk_vld  <= 1'b0;
                    r_fault     <= 1'b1;
                end
                default: begin
                    r_state <= ST_FAULT;
                end
            endcase
        end
    end

    assign o_car_r      = r_car_r;
    assign o_car_y      = r_car_y;
    assign o_car_g      = r_car_g;
    assign o_car_arrow  = r_car_arrow;
    assign o_hmn_r      = r_hmn_r;
    assign o_hmn_g      = r_hmn_g;
    assign o_walk_cnt   = r_walk_cnt;
    assign o_walk_vld   = r_walk_vld;
    assign o_fault      = r_fault;
    assign o_fault_code = r_fault_code;
    assign o_dbg_state  = (r_state == ST_FAULT);

endmodule

// File: tb/tb_traffic_lamp_driver.sv
// Directed bench for traffic_lamp_driver with a reference model feeding an
// expected-value queue, plus explicit pattern checks from the test plan.
module tb_traffic_lamp_driver;

    localparam int BH = 2;
    localparam int WC = 20;
    localparam int CW = 6;
    localparam int VW = CW + 10;

    localparam logic [1:0] C_R = 2'b00, C_G = 2'b01, C_Y = 2'b10, C_L = 2'b11;
    localparam logic [1:0] H_R = 2'b00, H_G = 2'b01, H_B = 2'b10, H_X = 2'b11;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    car = 2'b00;
    logic [1:0]    hmn = 2'b00;
    logic          o_car_r, o_car_y, o_car_g, o_car_arrow, o_hmn_r, o_hmn_g;
    logic [CW-1:0] o_walk_cnt;
    logic          o_walk_vld, o_fault, o_dbg_state;
    logic [1:0]    o_fault_code;

    traffic_lamp_driver #(
        .BLINK_HALF (BH),
        .WALK_CYCLES(WC),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_car_light (car),
        .i_hmn_light (hmn),
        .o_car_r     (o_car_r),
        .o_car_y     (o_car_y),
        .o_car_g     (o_car_g),
        .o_car_arrow (o_car_arrow),
        .o_hmn_r     (o_hmn_r),
        .o_hmn_g     (o_hmn_g),
        .o_walk_cnt  (o_walk_cnt),
        .o_walk_vld  (o_walk_vld),
        .o_fault     (o_fault),
        .o_fault_code(o_fault_code),
        .o_dbg_state (o_dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard
    logic [VW-1:0] exp_q[$];

    // Reference model state
    bit         m_fault;
    logic [1:0] m_code;
    logic [1:0] m_pcar, m_phmn;
    int         m_blink, m_flash, m_cnt;
    bit         m_vld;
    bit         e_cr, e_cy, e_cg, e_ca, e_hr, e_hg;

    function automatic logic [VW-1:0] obs_vec();
        return {o_car_r, o_car_y, o_car_g, o_car_arrow, o_hmn_r, o_hmn_g,
                o_walk_cnt, o_walk_vld, o_fault, o_fault_code};
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] model_vec();
        return {e_cr, e_cy, e_cg, e_ca, e_hr, e_hg, CW'(m_cnt), m_vld, m_fault, m_code};
    endfunction

    task automatic model_reset();
        m_fault = 0; m_code = 2'b00; m_pcar = C_R; m_phmn = H_R;
        m_blink = 0; m_flash = 0; m_cnt = 0; m_vld = 0;
        e_cr = 1; e_cy = 0; e_cg = 0; e_ca = 0; e_hr = 1; e_hg = 0;
        exp_q.push_back(model_vec());
    endtask

    task automatic model_step(input logic [1:0] c, input logic [1:0] h);
        bit conflict, car_ok, hmn_ok;
        logic [1:0] code;
        if (m_fault) begin
            m_flash = (m_flash + 1) % (2 * BH);
        end else begin
            conflict = (h == H_G || h == H_B) && (c != C_R);
            car_ok = (c == m_pcar) ||
                     (m_pcar == C_R && c == C_G) || (m_pcar == C_G && c == C_Y) ||
                     (m_pcar == C_Y && c == C_L) || (m_pcar == C_Y && c == C_R) ||
                     (m_pcar == C_L && c == C_Y);
            hmn_ok = (h != H_X) &&
                     ((h == m_phmn) || (m_phmn == H_R && h == H_G) ||
                      (m_phmn == H_G && h == H_B) || (m_phmn == H_B && h == H_R));
            code = conflict ? 2'b01 : (!car_ok ? 2'b10 : (!hmn_ok ? 2'b11 : 2'b00));
            if (code != 2'b00) begin
                m_fault = 1; m_code = code; m_flash = 0; m_cnt = 0; m_vld = 0;
            end else begin
                if (h == H_B) m_blink = (m_phmn != H_B) ? 0 : (m_blink + 1) % (2 * BH);
                else m_blink = 0;
                if (h == H_G && m_phmn == H_R) begin
                    m_cnt = WC - 1; m_vld = 1;
                end else if (h == H_G || h == H_B) begin
                    if (m_cnt > 0) m_cnt = m_cnt - 1;
                end else begin
                    m_cnt = 0; m_vld = 0;
                end
                e_cr = (c == C_R) || (c == C_L);
                e_cy = (c == C_Y);
                e_cg = (c == C_G);
                e_ca = (c == C_L);
                e_hr = (h == H_R);
                e_hg = (h == H_G) || (h == H_B && m_blink < BH);
                m_pcar = c; m_phmn = h;
            end
        end
        if (m_fault) begin
            e_cr = 0; e_cy = (m_flash < BH); e_cg = 0; e_ca = 0; e_hr = 0; e_hg = 0;
        end
        exp_q.push_back(model_vec());
    endtask

    task automatic sb_pop(input string tag);
        logic [VW-1:0] exp;
        n_checks++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s observed=output expected=queued entry (queue empty)", tag);
        end
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            chk(tag, obs_vec(), exp);
        end
    endtask

    // Driver tasks
    task automatic step(input logic [1:0] c, input logic [1:0] h, input string tag);
        car = c; hmn = h;
        model_step(c, h);
        @(posedge clk); #1;
        sb_pop(tag);
    endtask

    task automatic do_reset(input int n);
        rst_n = 0; car = C_G; hmn = H_X;
        for (int i = 0; i < n; i++) begin
            model_reset();
            @(posedge clk); #1;
            sb_pop("reset");
        end
        rst_n = 1; car = C_R; hmn = H_R;
    endtask

    logic [5:0] blink_pat;

    initial begin
        blink_pat = 6'b110011;

        // Reset state, with hostile inputs held during reset
        do_reset(2);
        chk_bit("reset_car_r", o_car_r, 1'b1);
        chk_bit("reset_hmn_r", o_hmn_r, 1'b1);

        // Normal car cycle with pedestrians held on RED
        step(C_R, H_R, "car_red");
        for (int i = 0; i < 14; i++) step(C_G, H_R, "car_green");
        for (int i = 0; i < 2; i++)  step(C_Y, H_R, "car_yellow");
        for (int i = 0; i < 10; i++) begin
            step(C_L, H_R, "car_left");
            chk_bit("arrow_left", o_car_arrow, 1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            step(C_Y, H_R, "car_yellow2");
            chk_bit("arrow_off", o_car_arrow, 1'b0);
        end
        step(C_R, H_R, "car_red2");
        chk_bit("no_fault_car_cycle", o_fault, 1'b0);

        // Pedestrian phase: 19..0 across GREEN x14 + BLINK x6
        for (int k = 0; k < 14; k++) begin
            step(C_R, H_G, "ped_green");
            chk("walk_cnt_green", {10'd0, o_walk_cnt}, {10'd0, CW'(WC - 1 - k)});
        end
        for (int k = 0; k < 6; k++) begin
            step(C_R, H_B, "ped_blink");
            chk("walk_cnt_blink", {10'd0, o_walk_cnt}, {10'd0, CW'(5 - k)});
            chk_bit("blink_hmn_g", o_hmn_g, blink_pat[5-k]);
            chk_bit("blink_hmn_r", o_hmn_r, 1'b0);
        end
        step(C_R, H_R, "ped_red");
        chk_bit("walk_vld_drop", o_walk_vld, 1'b0);

        // Conflict: car GREEN with pedestrian GREEN on the same edge
        step(C_G, H_G, "conflict");
        chk("conflict_code", {14'd0, o_fault_code}, {14'd0, 2'b01});
        for (int k = 1; k < 8; k++) begin
            step(C_R, H_R, "conflict_flash");
            chk_bit("flash_car_y", o_car_y, (k % 4) < 2);
        end

        // Reset out of FAULT, then illegal car GREEN -> RED
        do_reset(1);
        chk_bit("reset_clears_fault", o_fault, 1'b0);
        step(C_R, H_R, "ill_car_red");
        step(C_G, H_R, "ill_car_green");
        step(C_R, H_R, "ill_car_bad");
        chk("ill_car_code", {14'd0, o_fault_code}, {14'd0, 2'b10});
        step(C_R, H_X, "ill_car_then_hmn");
        step(C_G, H_G, "ill_car_then_conflict");
        chk("code_held", {14'd0, o_fault_code}, {14'd0, 2'b10});

        // Illegal pedestrian encoding
        do_reset(1);
        step(C_R, H_X, "hmn_enc");
        chk("hmn_enc_code", {14'd0, o_fault_code}, {14'd0, 2'b11});

        // Priority: conflict beats illegal car transition
        do_reset(1);
        step(C_Y, H_G, "prio_conflict");
        // Priority: illegal car beats illegal pedestrian
        do_reset(1);
        step(C_Y, H_X, "prio_car");

        // Reset mid-blink / mid-countdown, then RED->BLINK is illegal
        do_reset(1);
        for (int i = 0; i < 3; i++) step(C_R, H_G, "mid_green");
        for (int i = 0; i < 2; i++) step(C_R, H_B, "mid_blink");
        do_reset(1);
        step(C_R, H_B, "hmn_red_to_blink");
        chk("red_blink_code", {14'd0, o_fault_code}, {14'd0, 2'b11});

        // After reset a legal sequence runs normally
        do_reset(1);
        step(C_R, H_R, "post_red");
        for (int i = 0; i < 3; i++) step(C_G, H_R, "post_green");
        step(C_Y, H_R, "post_yellow");
        step(C_R, H_R, "post_red2");
        chk_bit("post_no_fault", o_fault, 1'b0);
        chk_bit("post_dbg_state", o_dbg_state, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
